// File: rtl/stopwatch_ctrl_pkg.sv
// Shared widths, FSM state encoding, digit-enable patterns and the packed mm:ss BCD layout
// for the stopwatch controller.
package stopwatch_ctrl_pkg;

    localparam int SSD_SCAN_CTL_BIT_WIDTH = 2;
    localparam int BCD_BIT_WIDTH          = 4;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_RUN   = 2'd1,
        STATE_PAUSE = 2'd2
    } state_t;

    // Active-low digit enables, DIG0 is the rightmost digit
    localparam logic [3:0] SSD_DIG0    = 4'b1110;
    localparam logic [3:0] SSD_DIG1    = 4'b1101;
    localparam logic [3:0] SSD_DIG2    = 4'b1011;
    localparam logic [3:0] SSD_DIG3    = 4'b0111;
    localparam logic [3:0] SSD_DIG_OFF = 4'b1111;

    typedef struct packed {
        logic [BCD_BIT_WIDTH-1:0] min_tens;
        logic [BCD_BIT_WIDTH-1:0] min_units;
        logic [BCD_BIT_WIDTH-1:0] sec_tens;
        logic [BCD_BIT_WIDTH-1:0] sec_units;
    } time_t;

endpackage

// File: rtl/stopwatch_ctrl_digit.sv
// One BCD digit that rolls over from LIMIT to 0, with a combinational carry for chaining.
// Latency: q updates on the clock edge after inc/clr; carry is combinational.
// Backpressure: none; inc is a single-cycle enable that is always accepted.
module bcd_digit_counter
    import stopwatch_ctrl_pkg::*;
#(
    parameter int LIMIT = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [BCD_BIT_WIDTH-1:0] q,
    output logic                     carry
);

    localparam logic [BCD_BIT_WIDTH-1:0] LIM = BCD_BIT_WIDTH'(LIMIT);

    logic at_limit;

    assign at_limit = (q == LIM);
    assign carry    = inc & at_limit;

    // Clear outranks increment so a wrap and a clear in the same cycle both land on 0
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= at_limit ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/pause/clear FSM, mm:ss BCD count and registered seven-segment scan mux.
// Latency: input edge -> state/time 1 clk; scan_ctl -> ssd_ctl/bcd_out 1 clk.
// Backpressure: none; every detected input edge is acted on in the cycle it is seen.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int SEC_LIMIT = 59,
    parameter int MIN_LIMIT = 59
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tick,
    input  logic [SSD_SCAN_CTL_BIT_WIDTH-1:0] scan_ctl,
    input  logic                              start_stop,
    input  logic                              clear,
    output logic                              running,
    output logic [15:0]                       time_bcd,
    output logic [3:0]                        ssd_ctl,
    output logic [BCD_BIT_WIDTH-1:0]          bcd_out
);

    logic   tick_q, ss_q, clr_q;
    logic   tick_rise, ss_rise, clr_rise;
    state_t state_q, state_d;
    logic   cnt_inc, cnt_clr;
    logic   su_carry, st_carry, mu_carry, mt_carry;
    time_t  t;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
            ss_q   <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            tick_q <= tick;
            ss_q   <= start_stop;
            clr_q  <= clear;
        end
    end

    assign tick_rise = tick & ~tick_q;
    assign ss_rise   = start_stop & ~ss_q;
    assign clr_rise  = clear & ~clr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= (state_d == STATE_RUN);
        end
    end

    // Clear wins over start/stop outside RUN; clear is ignored while running
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (clr_rise) begin
                    cnt_clr = 1'b1;
                end else if (ss_rise) begin
                    state_d = STATE_RUN;
                end
            end
            STATE_RUN: begin
                cnt_inc = tick_rise;
                if (ss_rise) begin
                    state_d = STATE_PAUSE;
                end
            end
            STATE_PAUSE: begin
                if (clr_rise) begin
                    cnt_clr = 1'b1;
                    state_d = STATE_IDLE;
                end else if (ss_rise) begin
                    state_d = STATE_RUN;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    bcd_digit_counter #(.LIMIT(9)) u_sec_units (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .q     (t.sec_units),
        .carry (su_carry)
    );

    bcd_digit_counter #(.LIMIT(SEC_LIMIT / 10)) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (su_carry),
        .q     (t.sec_tens),
        .carry (st_carry)
    );

    // Terminal minute rollover also clears the whole minutes field back to 00
    bcd_digit_counter #(.LIMIT(9)) u_min_units (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr | mt_carry),
        .inc   (st_carry),
        .q     (t.min_units),
        .carry (mu_carry)
    );

    bcd_digit_counter #(.LIMIT(MIN_LIMIT / 10)) u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr | mt_carry),
        .inc   (mu_carry),
        .q     (t.min_tens),
        .carry (mt_carry)
    );

    assign time_bcd = t;

    always_ff @(posedge clk) begin
        if (rst) begin
            ssd_ctl <= SSD_DIG_OFF;
            bcd_out <= '0;
        end else begin
            case (scan_ctl)
                2'd0: begin ssd_ctl <= SSD_DIG0; bcd_out <= t.sec_units; end
                2'd1: begin ssd_ctl <= SSD_DIG1; bcd_out <= t.sec_tens;  end
                2'd2: begin ssd_ctl <= SSD_DIG2; bcd_out <= t.min_units; end
                default: begin ssd_ctl <= SSD_DIG3; bcd_out <= t.min_tens; end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed stimulus for stopwatch_ctrl; expectations are queued with a target cycle
// and a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [1:0]  scan_ctl = 2'd0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        running;
    logic [15:0] time_bcd;
    logic [3:0]  ssd_ctl;
    logic [3:0]  bcd_out;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .scan_ctl   (scan_ctl),
        .start_stop (start_stop),
        .clear      (clear),
        .running    (running),
        .time_bcd   (time_bcd),
        .ssd_ctl    (ssd_ctl),
        .bcd_out    (bcd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_state;
        bit          chk_scan;
        logic        run;
        logic [15:0] tm;
        logic [3:0]  ssd;
        logic [3:0]  bcd;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        while (sb.size() != 0 && sb[0].cyc <= cycle) begin
            e = sb.pop_front();
            vectors++;
            bad = (e.cyc != cycle);
            if (e.chk_state && (running !== e.run || time_bcd !== e.tm)) bad = 1'b1;
            if (e.chk_scan && (ssd_ctl !== e.ssd || bcd_out !== e.bcd)) bad = 1'b1;
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got running=%b time=%h ssd=%b bcd=%h, want running=%b time=%h ssd=%b bcd=%h",
                         e.name, running, time_bcd, ssd_ctl, bcd_out, e.run, e.tm, e.ssd, e.bcd);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_state(input string nm, input logic r, input logic [15:0] tm);
        exp_t e;
        e.cyc = cycle; e.name = nm; e.chk_state = 1'b1; e.chk_scan = 1'b0;
        e.run = r; e.tm = tm; e.ssd = 4'h0; e.bcd = 4'h0;
        sb.push_back(e);
    endtask

    task automatic exp_scan(input string nm, input logic [3:0] ssd, input logic [3:0] bcd);
        exp_t e;
        e.cyc = cycle; e.name = nm; e.chk_state = 1'b0; e.chk_scan = 1'b1;
        e.run = 1'b0; e.tm = 16'h0; e.ssd = ssd; e.bcd = bcd;
        sb.push_back(e);
    endtask

    // Raise the chosen levels for one cycle, then drop them and let one more edge pass
    task automatic pulse(input bit ss, input bit cl, input bit tk);
        start_stop = ss; clear = cl; tick = tk;
        step(1);
        start_stop = 1'b0; clear = 1'b0; tick = 1'b0;
        step(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        step(2);
        exp_state("reset_state", 1'b0, 16'h0000);
        exp_scan("reset_scan", 4'b1111, 4'h0);
        rst = 1'b0;
        step(1);

        tick = 1'b1; step(5); tick = 1'b0; step(1);
        exp_state("idle_no_count", 1'b0, 16'h0000);

        pulse(1'b1, 1'b0, 1'b0);
        exp_state("start", 1'b1, 16'h0000);
        ticks(10);
        exp_state("ten_ticks", 1'b1, 16'h0010);
        tick = 1'b1; step(100); tick = 1'b0; step(1);
        exp_state("held_tick_once", 1'b1, 16'h0011);

        ticks(588);
        exp_state("at_0959", 1'b1, 16'h0959);
        ticks(1);
        exp_state("0959_to_1000", 1'b1, 16'h1000);
        ticks(2999);
        exp_state("at_5959", 1'b1, 16'h5959);
        ticks(1);
        exp_state("wrap_0000", 1'b1, 16'h0000);

        ticks(7);
        exp_state("at_0007", 1'b1, 16'h0007);
        pulse(1'b1, 1'b0, 1'b0);
        exp_state("pause", 1'b0, 16'h0007);
        ticks(5);
        exp_state("pause_holds", 1'b0, 16'h0007);
        pulse(1'b0, 1'b1, 1'b0);
        exp_state("clear_pause", 1'b0, 16'h0000);

        pulse(1'b1, 1'b0, 1'b0);
        ticks(3);
        exp_state("rerun_0003", 1'b1, 16'h0003);
        pulse(1'b0, 1'b1, 1'b0);
        exp_state("clear_in_run_ignored", 1'b1, 16'h0003);
        ticks(1);
        exp_state("at_0004", 1'b1, 16'h0004);

        tick = 1'b1; start_stop = 1'b1;
        step(1);
        exp_state("tick_and_ss", 1'b0, 16'h0005);
        tick = 1'b0; start_stop = 1'b0;
        step(1);
        ticks(2);
        exp_state("paused_after_both", 1'b0, 16'h0005);

        pulse(1'b1, 1'b1, 1'b0);
        exp_state("ss_clr_pause", 1'b0, 16'h0000);
        pulse(1'b1, 1'b1, 1'b0);
        exp_state("ss_clr_idle", 1'b0, 16'h0000);
        ticks(1);
        exp_state("idle_after_both", 1'b0, 16'h0000);

        pulse(1'b1, 1'b0, 1'b0);
        ticks(753);
        exp_state("at_1233", 1'b1, 16'h1233);
        exp_scan("scan_1233", 4'b1110, 4'h3);
        tick = 1'b1;
        step(1);
        exp_state("at_1234", 1'b1, 16'h1234);
        exp_scan("display_lags_count", 4'b1110, 4'h3);
        tick = 1'b0;
        step(1);
        exp_scan("display_catches_up", 4'b1110, 4'h4);
        pulse(1'b1, 1'b0, 1'b0);
        exp_state("pause_1234", 1'b0, 16'h1234);

        scan_ctl = 2'd0; step(1); exp_scan("scan0", 4'b1110, 4'h4);
        scan_ctl = 2'd1; step(1); exp_scan("scan1", 4'b1101, 4'h3);
        scan_ctl = 2'd2; step(1); exp_scan("scan2", 4'b1011, 4'h2);
        scan_ctl = 2'd3; step(1); exp_scan("scan3", 4'b0111, 4'h1);

        scan_ctl = 2'd1; rst = 1'b1;
        step(1);
        exp_scan("rst_mid_sweep_scan", 4'b1111, 4'h0);
        exp_state("rst_mid_sweep_state", 1'b0, 16'h0000);
        rst = 1'b0;
        step(1);
        exp_scan("after_rst_scan", 4'b1101, 4'h0);

        step(2);
        for (int i = 0; i < 10 && sb.size() != 0; i++) step(1);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1);
    end

endmodule
